switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Router-level switch allocator, directly downstream of each input port's head-flit buffer.
- Collects route-reserve requests (target output port index) from all input ports.
- Arbitrates each output port round-robin, holds the reservation until the owning input relieves it, and drives crossbar select lines.
- Grants return to input ports as the routeReserveStatus pulse.

Parameters:
- PORTS, 5, number of router input ports (= output ports)
- REQUEST_WIDTH, 3, width of one request index; must be >= $clog2(PORTS)
- CNT_WIDTH, 16, width of optional grant counters

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- routeReserveRequestValid  input  PORTS  per input port; request pending
- routeReserveRequest  input  PORTS*REQUEST_WIDTH  per input port; target output index, slice i at [i*REQUEST_WIDTH +: REQUEST_WIDTH]
- routeRelieve  input  PORTS  per input port; one-cycle pulse, tail flit done, release held output
- routeReserveStatus  output  PORTS  per input port; one-cycle grant pulse
- outputBusy  output  PORTS  per output port; reserved
- outputOwner  output  PORTS*REQUEST_WIDTH  per output port; owning input index (crossbar select)
- inputHolds  output  PORTS  per input port; currently owns an output
- grantCount  output  PORTS*CNT_WIDTH  present only with SWITCH_ALLOC_GRANT_COUNT_EN

Behaviour:
- Reset asserts immediately and asynchronously.
  - All outputs are 0.
  - Every output is Free; all round-robin pointers are 0; all owners are 0.
- Per-output FSM, 2 states:
  - Free -> Reserved when a grant is issued for that output.
  - Reserved -> Free on the owner's routeRelieve.
  - The Reserved state holds regardless of other requests.
- Eligible requester for output o in cycle t, all conditions required:
  - routeReserveRequestValid[i]=1.
  - routeReserveRequest slice i == o.
  - inputHolds[i]=0.
  - routeReserveStatus[i]=0 in cycle t. This masks the requester's still-high valid in its grant cycle.
- Grant rules:
  - A Free output o with at least one eligible requester grants exactly one of them.
  - The winner is the first eligible index searching from rrPtr[o] upward, wrapping at PORTS-1 -> 0.
  - Grant is registered. The request sampled at edge t produces a routeReserveStatus[i]=1 pulse for exactly cycle t+1.
  - In the same edge: outputBusy[o]=1, outputOwner[o]=i, inputHolds[i]=1, rrPtr[o]=(i+1) mod PORTS.
- At most one grant per input per cycle. An input targets exactly one output, so no input-side conflict is possible.
- Release: routeRelieve[i]=1 with inputHolds[i]=1 frees the output owned by i at the next edge.
  - outputBusy and inputHolds clear; outputOwner keeps its last value.
  - routeRelieve on an input that holds nothing is ignored.
- Release and request for the same output in the same cycle:
  - Arbitration uses the registered Busy state, so the output is not re-granted that cycle.
  - The earliest new grant pulse is 2 cycles after the relieve cycle.
- Request index >= PORTS: ignored, never granted.
- Requester drops valid before grant: no grant is issued, no state changes.
- Self-routing (input i to output i) is legal and treated normally.
- Latency: best case 1 cycle from valid to status pulse; no combinational path from inputs to any output.

Optional Feature:
- Macro: SWITCH_ALLOC_GRANT_COUNT_EN.
- Defined:
  - One CNT_WIDTH saturating counter per output port, incremented on each grant issued for that output.
  - Stops at all-ones.
  - Cleared by rst.
  - Exposed on grantCount, slice o at [o*CNT_WIDTH +: CNT_WIDTH].
- Undefined: port grantCount and counters do not exist; allocation behaviour is identical.

Test Plan:
- Single request: reset, input 2 requests output 4 at cycle 3 -> routeReserveStatus[2]=1 in cycle 4 only; outputBusy[4]=1, outputOwner[4]=2, inputHolds[2]=1 from cycle 4.
- Contention and round-robin:
  - Setup: inputs 0,1,3 all request output 1 and hold valid until granted; each relieves 3 cycles after its grant.
  - Required response: grant order is 0, 1, 3, and rrPtr[1] ends at 4.
  - Repeat: an identical batch is granted in order 0, 1, 3 again.
- Hold and release: input 0 owns output 2, input 4 requests output 2 for 10 cycles -> no grant while Busy. Pulse routeRelieve[0] at cycle 20 -> outputBusy[2]=0 in cycle 21, routeReserveStatus[4]=1 in cycle 22.
- Parallel outputs: inputs 0..4 request outputs 4,3,2,1,0 in the same cycle -> all five status bits pulse together the next cycle; outputOwner = {0,1,2,3,4} for outputs 4..0.
- Boundaries:
  - Request index 7 with PORTS=5 -> never granted.
  - routeRelieve on an idle input -> no change.
  - rst asserted mid-reservation, between clock edges -> all outputs 0 immediately.
- With SWITCH_ALLOC_GRANT_COUNT_EN and CNT_WIDTH=2: 5 grants on output 0 -> grantCount slice 0 reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/switch_allocator.sv
// Router switch allocator.
//
// Collects route-reserve requests from every input port, arbitrates each output port
// round-robin, holds a reservation until the owning input relieves it, and drives the
// crossbar select lines. All outputs come straight from flops.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   routeReserveRequestValid   per input: request pending
//   routeReserveRequest        per input: target output index, slice i at [i*REQUEST_WIDTH +:]
//   routeRelieve               per input: one-cycle pulse releasing the held output
//   routeReserveStatus         per input: one-cycle grant pulse
//   outputBusy                 per output: reserved
//   outputOwner                per output: owning input index (crossbar select)
//   inputHolds                 per input: currently owns an output
//   grantCount                 per output saturating grant counter, only with
//                              SWITCH_ALLOC_GRANT_COUNT_EN defined
module switch_allocator #(
    parameter int unsigned PORTS         = 5,
    parameter int unsigned REQUEST_WIDTH = 3,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORTS-1:0]               routeReserveRequestValid,
    input  logic [PORTS*REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic [PORTS-1:0]               routeRelieve,
    output logic [PORTS-1:0]               routeReserveStatus,
    output logic [PORTS-1:0]               outputBusy,
    output logic [PORTS*REQUEST_WIDTH-1:0] outputOwner,
    output logic [PORTS-1:0]               inputHolds
`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
    ,
    output logic [PORTS*CNT_WIDTH-1:0]     grantCount
`endif
);

    typedef enum logic {StFree, StReserved} out_state_e;

    out_state_e               state_q  [PORTS];
    out_state_e               state_d  [PORTS];
    logic [REQUEST_WIDTH-1:0] owner_q  [PORTS];
    logic [REQUEST_WIDTH-1:0] owner_d  [PORTS];
    logic [REQUEST_WIDTH-1:0] rr_ptr_q [PORTS];
    logic [REQUEST_WIDTH-1:0] rr_ptr_d [PORTS];
    logic [PORTS-1:0]         holds_q, holds_d;
    logic [PORTS-1:0]         status_q, status_d;
    logic [PORTS-1:0]         elig     [PORTS];

    // elig[o][i]: input i may win output o this cycle. The status mask keeps a requester
    // whose valid is still high during its own grant pulse from being granted twice.
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            elig[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                elig[o][i] = routeReserveRequestValid[i] && !holds_q[i] && !status_q[i] &&
                             (routeReserveRequest[i*REQUEST_WIDTH +: REQUEST_WIDTH] ==
                              REQUEST_WIDTH'(o));
            end
        end
    end

    always_comb begin
        logic                     found;
        logic [REQUEST_WIDTH-1:0] win;
        logic [PORTS-1:0]         win_oh;

        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        holds_d  = holds_q;
        status_d = '0;
        found    = 1'b0;
        win      = '0;
        win_oh   = '0;

        // Release: the owner's relieve frees its output at the next edge.
        for (int o = 0; o < PORTS; o++) begin
            if (state_q[o] == StReserved) begin
                for (int i = 0; i < PORTS; i++) begin
                    if (owner_q[o] == REQUEST_WIDTH'(i) && routeRelieve[i] && holds_q[i]) begin
                        state_d[o] = StFree;
                        holds_d[i] = 1'b0;
                    end
                end
            end
        end

        // Grant: only outputs Free in the registered state compete, so an output being
        // released this cycle is not re-granted until the following one.
        for (int o = 0; o < PORTS; o++) begin
            found  = 1'b0;
            win    = '0;
            win_oh = '0;
            if (state_q[o] == StFree) begin
                // First pass covers indices at/above the pointer, second pass wraps to 0.
                for (int i = 0; i < PORTS; i++) begin
                    if (!found && REQUEST_WIDTH'(i) >= rr_ptr_q[o] && elig[o][i]) begin
                        found     = 1'b1;
                        win       = REQUEST_WIDTH'(i);
                        win_oh[i] = 1'b1;
                    end
                end
                for (int i = 0; i < PORTS; i++) begin
                    if (!found && elig[o][i]) begin
                        found     = 1'b1;
                        win       = REQUEST_WIDTH'(i);
                        win_oh[i] = 1'b1;
                    end
                end
            end
            if (found) begin
                state_d[o]  = StReserved;
                owner_d[o]  = win;
                rr_ptr_d[o] = (win == REQUEST_WIDTH'(PORTS - 1)) ? '0 : win + 1'b1;
                holds_d     = holds_d | win_oh;
                status_d    = status_d | win_oh;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o]  <= StFree;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
            holds_q  <= '0;
            status_q <= '0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
            holds_q  <= holds_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        outputBusy  = '0;
        outputOwner = '0;
        for (int o = 0; o < PORTS; o++) begin
            outputBusy[o]                                  = (state_q[o] == StReserved);
            outputOwner[o*REQUEST_WIDTH +: REQUEST_WIDTH] = owner_q[o];
        end
    end

    assign routeReserveStatus = status_q;
    assign inputHolds         = holds_q;

`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q [PORTS];
    logic [CNT_WIDTH-1:0] cnt_d [PORTS];

    // A Free -> Reserved transition is exactly one grant for that output.
    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            cnt_d[o] = cnt_q[o];
            if (state_q[o] == StFree && state_d[o] == StReserved && cnt_q[o] != '1) begin
                cnt_d[o] = cnt_q[o] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < PORTS; o++) begin
                cnt_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                cnt_q[o] <= cnt_d[o];
            end
        end
    end

    always_comb begin
        grantCount = '0;
        for (int o = 0; o < PORTS; o++) begin
            grantCount[o*CNT_WIDTH +: CNT_WIDTH] = cnt_q[o];
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

    localparam int P  = 5;
    localparam int RW = 3;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [P-1:0]    valid_v = '0;
    logic [P*RW-1:0] req_v = '0;
    logic [P-1:0]    relieve_v = '0;
    logic [P-1:0]    status_o;
    logic [P-1:0]    busy_o;
    logic [P*RW-1:0] owner_o;
    logic [P-1:0]    holds_o;
`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
    logic [P*CW-1:0] count_o;
`endif

    switch_allocator #(
        .PORTS         (P),
        .REQUEST_WIDTH (RW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .routeReserveRequestValid (valid_v),
        .routeReserveRequest      (req_v),
        .routeRelieve             (relieve_v),
        .routeReserveStatus       (status_o),
        .outputBusy               (busy_o),
        .outputOwner              (owner_o),
        .inputHolds               (holds_o)
`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
        ,
        .grantCount               (count_o)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: per-output busy/owner/pointer, per-input holds/status, grant counts.
    int m_busy[P], m_owner[P], m_ptr[P], m_holds[P], m_status[P], m_cnt[P];
    int n_busy[P], n_owner[P], n_ptr[P], n_holds[P], n_status[P], n_cnt[P];

    // Requester agents.
    int want[P], tgt[P], hold_len[P], age[P], grant_cyc[P];
    logic [P-1:0] extra_rel = '0;
    int grant_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [P*RW-1:0] obs,
                           input logic [P*RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < P; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
            m_holds[k] = 0; m_status[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic agent_reset();
        for (int k = 0; k < P; k++) begin
            want[k] = 0; tgt[k] = 0; hold_len[k] = 0; age[k] = 0; grant_cyc[k] = -1;
        end
        extra_rel = '0;
        grant_q.delete();
    endtask

    // Next state from the allocation rules, using the inputs currently driven.
    task automatic model_step();
        for (int k = 0; k < P; k++) begin
            n_busy[k] = m_busy[k]; n_owner[k] = m_owner[k]; n_ptr[k] = m_ptr[k];
            n_holds[k] = m_holds[k]; n_status[k] = 0; n_cnt[k] = m_cnt[k];
        end
        for (int i = 0; i < P; i++) begin
            if (relieve_v[i] && m_holds[i] != 0) begin
                n_holds[i] = 0;
                for (int o = 0; o < P; o++)
                    if (m_busy[o] != 0 && m_owner[o] == i) n_busy[o] = 0;
            end
        end
        for (int o = 0; o < P; o++) begin
            if (m_busy[o] == 0) begin
                for (int k = 0; k < P; k++) begin
                    int i;
                    i = (m_ptr[o] + k) % P;
                    if (valid_v[i] && int'(req_v[i*RW +: RW]) == o && m_holds[i] == 0 &&
                        m_status[i] == 0) begin
                        n_busy[o] = 1; n_owner[o] = i; n_holds[i] = 1; n_status[i] = 1;
                        n_ptr[o] = (i + 1) % P;
                        if (m_cnt[o] < CMAX) n_cnt[o] = m_cnt[o] + 1;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [P-1:0]    e_st, e_busy, e_holds;
        logic [P*RW-1:0] e_own;
        logic [RW-1:0]   w;
        e_st = '0; e_busy = '0; e_holds = '0; e_own = '0;
        for (int k = 0; k < P; k++) begin
            e_st[k] = (m_status[k] != 0);
            e_busy[k] = (m_busy[k] != 0);
            e_holds[k] = (m_holds[k] != 0);
            w = RW'(m_owner[k]);
            e_own[k*RW +: RW] = w;
        end
        chk({tag, ".status"}, int'(status_o), int'(e_st));
        chk({tag, ".busy"}, int'(busy_o), int'(e_busy));
        chk({tag, ".holds"}, int'(holds_o), int'(e_holds));
        chk_vec({tag, ".owner"}, owner_o, e_own);
`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
        for (int k = 0; k < P; k++) chk({tag, ".count"}, int'(count_o[k*CW +: CW]), m_cnt[k]);
`endif
    endtask

    task automatic drive();
        logic [RW-1:0] t;
        for (int i = 0; i < P; i++) begin
            valid_v[i] = (want[i] != 0) || (m_status[i] != 0);
            t = RW'(tgt[i]);
            req_v[i*RW +: RW] = t;
            relieve_v[i] = (m_holds[i] != 0 && age[i] >= hold_len[i]) || extra_rel[i];
        end
    endtask

    task automatic cycle(input string tag);
        drive();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < P; k++) begin
            m_busy[k] = n_busy[k]; m_owner[k] = n_owner[k]; m_ptr[k] = n_ptr[k];
            m_holds[k] = n_holds[k]; m_status[k] = n_status[k]; m_cnt[k] = n_cnt[k];
        end
        for (int i = 0; i < P; i++) begin
            if (m_status[i] != 0) begin
                want[i] = 0; age[i] = 0; grant_cyc[i] = cyc; grant_q.push_back(i);
            end else if (m_holds[i] != 0) begin
                age[i]++;
            end
        end
        check_all(tag);
    endtask

    initial begin
        int rc;
        model_reset();
        agent_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Single request: input 2 -> output 4.
        want[2] = 1; tgt[2] = 4; hold_len[2] = 5;
        cycle("single");
        chk("single.pulse", int'(status_o[2]), 1);
        chk("single.busy4", int'(busy_o[4]), 1);
        chk("single.owner4", int'(owner_o[4*RW +: RW]), 2);
        chk("single.holds2", int'(holds_o[2]), 1);
        cycle("single2");
        chk("single.pulse_once", int'(status_o[2]), 0);
        repeat (8) cycle("single_drain");

        // Contention on output 1, two identical batches.
        for (int b = 0; b < 2; b++) begin
            grant_q.delete();
            for (int i = 0; i < P; i++) if (i != 2 && i != 4) begin
                want[i] = 1; tgt[i] = 1; hold_len[i] = 3;
            end
            repeat (20) cycle("rr");
            chk("rr.count", grant_q.size(), 3);
            if (grant_q.size() == 3) begin
                chk("rr.first", grant_q[0], 0);
                chk("rr.second", grant_q[1], 1);
                chk("rr.third", grant_q[2], 3);
            end
        end

        // Hold and release: input 0 owns output 2, input 4 waits.
        agent_reset();
        want[0] = 1; tgt[0] = 2; hold_len[0] = 1000;
        cycle("hold");
        want[4] = 1; tgt[4] = 2; hold_len[4] = 1;
        repeat (10) cycle("hold_wait");
        chk("hold.no_grant4", grant_cyc[4], -1);
        hold_len[0] = 0;
        rc = cyc;
        cycle("release");
        chk("release.busy2", int'(busy_o[2]), 0);
        cycle("release2");
        chk("release.pulse4", int'(status_o[4]), 1);
        chk("release.latency", grant_cyc[4] - rc, 2);
        repeat (4) cycle("release_drain");

        // Parallel outputs.
        agent_reset();
        for (int i = 0; i < P; i++) begin
            want[i] = 1; tgt[i] = P - 1 - i; hold_len[i] = 2;
        end
        cycle("parallel");
        chk("parallel.pulse", int'(status_o), 5'h1f);
        chk_vec("parallel.owner", owner_o, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        repeat (5) cycle("parallel_drain");

        // Out-of-range request index never granted.
        agent_reset();
        want[1] = 1; tgt[1] = 7;
        repeat (10) cycle("oor");
        chk("oor.no_grant", grant_q.size(), 0);
        want[1] = 0;

        // Relieve on an idle input is ignored.
        extra_rel[3] = 1'b1;
        cycle("idle_relieve");
        extra_rel = '0;
        chk("idle_relieve.busy", int'(busy_o), 0);

        // Asynchronous reset between edges while a reservation is held.
        want[0] = 1; tgt[0] = 3; hold_len[0] = 1000;
        cycle("pre_reset");
        cycle("pre_reset2");
        chk("pre_reset.busy3", int'(busy_o[3]), 1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        agent_reset();
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef SWITCH_ALLOC_GRANT_COUNT_EN
        for (int n = 1; n <= 5; n++) begin
            want[1] = 1; tgt[1] = 0; hold_len[1] = 0;
            cycle("cnt");
            chk("cnt.slice0", int'(count_o[CW-1:0]), (n > CMAX) ? CMAX : n);
            cycle("cnt_rel");
            cycle("cnt_idle");
        end
`endif

        // Randomized traffic against the model.
        agent_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < P; i++) begin
                if (want[i] == 0 && m_holds[i] == 0 && m_status[i] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        want[i] = 1;
                        tgt[i] = $urandom_range(0, 5);
                        hold_len[i] = $urandom_range(0, 4);
                    end
                    extra_rel[i] = ($urandom_range(0, 7) == 0);
                end else begin
                    extra_rel[i] = 1'b0;
                    if (want[i] != 0 && $urandom_range(0, 15) == 0) want[i] = 0;
                end
            end
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
